mips_cpu_sequencer: RTL and testbench
=====================================

// Module: mips_cpu_sequencer
// PURPOSE
//   Multicycle state sequencer for the MIPS CPU. Drives the 3-bit state consumed by the
//   control decoder (1=FETCH, 2=DECODE, 3=EXEC1, 4=EXEC2), with 0=HALTED.
//   Stalls on memory waitrequest, picks 1- or 2-cycle execute per opcode, halts on a
//   fetch from HALT_ADDR or on an unsupported instruction, and counts retired instructions.
// PARAMETERS
//   HALT_ADDR  32'h0000_0000  fetching from this PC halts the CPU
//   COUNT_W    32             width of instr_count
// PORTS
//   clk          in   1        single clock; all state updates on rising edge
//   reset        in   1        synchronous, active-high reset
//   opcode       in   6        IR[31:26], valid from DECODE onward
//   fncode       in   6        IR[5:0], valid from DECODE onward
//   pc           in   32       current PC register value
//   waitrequest  in   1        memory bus busy; current access not complete
//   state        out  3        sequencer state to control decoder
//   advance      out  1        1 = state changes this edge; datapath qualifies writes with it
//   bus_enable   out  1        0 = datapath must suppress memread/memwrite this cycle
//   active       out  1        1 while CPU running; 0 once HALTED
//   illegal      out  1        sticky: halted on unsupported instruction
//   instr_count  out  COUNT_W  retired instruction count
// BEHAVIOUR
//   Reset (sampled at edge): state=FETCH, active=1, illegal=0, instr_count=0. Wins over
//     everything, including mid-stall and HALTED.
//   Supported set: opcode 0x00 with fncode in {0x08,0x09,0x20..0x26}; opcodes 0x04, 0x05,
//     0x23, 0x2B. Single-exec = 0x04, 0x05. All other supported = two-exec.
//   mem_busy = waitrequest AND one of: FETCH (not halting); EXEC1 with opcode 0x23;
//     EXEC2 with opcode 0x2B. In all other states waitrequest is ignored.
//   advance = (state != HALTED) AND NOT mem_busy. state registers next only when advance=1.
//   Transitions:
//     FETCH:  pc==HALT_ADDR -> HALTED (advance=1, bus_enable=0); else -> DECODE
//     DECODE: unsupported -> HALTED with illegal set; else -> EXEC1 (no wait in DECODE)
//     EXEC1:  single-exec -> FETCH; else -> EXEC2
//     EXEC2:  -> FETCH
//     HALTED: stays HALTED until reset; advance=0, bus_enable=0, active=0
//   bus_enable = 1 in FETCH/DECODE/EXEC1/EXEC2 except the halting FETCH cycle.
//   active is registered: it falls on the edge that enters HALTED.
//   illegal is registered and set on the same edge.
//   instr_count increments by 1 on every advancing edge into FETCH from EXEC1/EXEC2.
//     It wraps modulo 2^COUNT_W. Halting FETCH and illegal DECODE do not count.
//   Stall holds state, and all outputs, stable for any number of cycles.
//     FETCH/EXEC1 stalls keep memread asserted via the decoder, since state is unchanged.
//   Latency: two-exec instr = 4 cycles + stalls; branch = 3 cycles + stalls.
//   opcode/fncode X or unsupported in EXEC1/EXEC2 is impossible by construction; the RTL
//     asserts on it in simulation only.
// TESTING
//   1. Reset, pc=0xBFC0_0000, add (op 0, fn 0x21), waitrequest=0 -> state 1,2,3,4,1;
//      advance=1 every cycle; instr_count 0->1 on the 4th edge.
//   2. beq (op 0x04) -> state 1,2,3,1; instr_count +1 after 3 cycles.
//   3. lw (op 0x23) with waitrequest=1 for 3 cycles in FETCH and 2 cycles in EXEC1 ->
//      state held, advance=0 in those cycles; total 9 cycles; waitrequest in DECODE
//      has no effect.
//   4. sw (op 0x2B) then jr to pc=0 -> EXEC2 holds under waitrequest. The next FETCH
//      with pc=0 gives bus_enable=0, then state=0 and active=0. instr_count = 2 (sw, jr).
//   5. Decode op 0x3F -> HALTED, illegal=1, active=0; waitrequest toggling keeps it
//      HALTED; reset -> state=1, illegal=0, instr_count=0.
//   6. Reset asserted mid-stall in EXEC1 with waitrequest=1 -> state=FETCH on next edge;
//      preload instr_count=2^COUNT_W-1 (force) and retire one -> wraps to 0.

Source files
------------

// File: rtl/mips_cpu_sequencer.sv
// Multicycle FETCH/DECODE/EXEC1/EXEC2 sequencer with halt detection and retired-instruction count.
// Latency: branch 3 cycles, other instrs 4 cycles, plus stalls; memory waitrequest holds state and outputs.
module mips_cpu_sequencer #(
    parameter logic [31:0] HALT_ADDR = 32'h0000_0000,
    parameter int          COUNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         fncode,
    input  logic [31:0]        pc,
    input  logic               waitrequest,
    output logic [2:0]         state,
    output logic               advance,
    output logic               bus_enable,
    output logic               active,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_HALTED = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC1  = 3'd3,
        S_EXEC2  = 3'd4
    } state_t;

    state_t cur, nxt;
    logic   supported, single_exec;
    logic   halt_fetch, mem_busy, retire;

    assign state = cur;

    always_comb begin
        supported   = 1'b0;
        single_exec = 1'b0;
        case (opcode)
            6'h00:        supported = (fncode == 6'h08) || (fncode == 6'h09) ||
                                      ((fncode >= 6'h20) && (fncode <= 6'h26));
            6'h04, 6'h05: begin
                supported   = 1'b1;
                single_exec = 1'b1;
            end
            6'h23, 6'h2B: supported = 1'b1;
            default:      supported = 1'b0;
        endcase
    end

    always_comb begin
        halt_fetch = (cur == S_FETCH) && (pc == HALT_ADDR);
        // Only the memory-touching phases honour waitrequest; a halting fetch issues no access.
        mem_busy   = waitrequest && (((cur == S_FETCH) && !halt_fetch) ||
                                     ((cur == S_EXEC1) && (opcode == 6'h23)) ||
                                     ((cur == S_EXEC2) && (opcode == 6'h2B)));
        advance    = (cur != S_HALTED) && !mem_busy;
        bus_enable = (cur != S_HALTED) && !halt_fetch;
        nxt        = cur;
        case (cur)
            S_FETCH:  nxt = halt_fetch ? S_HALTED : S_DECODE;
            S_DECODE: nxt = supported ? S_EXEC1 : S_HALTED;
            S_EXEC1:  nxt = single_exec ? S_FETCH : S_EXEC2;
            S_EXEC2:  nxt = S_FETCH;
            default:  nxt = S_HALTED;
        endcase
        retire = advance && (nxt == S_FETCH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= S_FETCH;
            active      <= 1'b1;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else if (advance) begin
            cur <= nxt;
            if (nxt == S_HALTED)
                active <= 1'b0;
            if ((cur == S_DECODE) && !supported)
                illegal <= 1'b1;
            if (retire)
                instr_count <= instr_count + COUNT_W'(1);
        end
    end

    // The instruction register is stable and decodable once past DECODE.
    assert property (@(posedge clk) disable iff (reset)
        ((cur == S_EXEC1) || (cur == S_EXEC2)) |-> (!$isunknown({opcode, fncode}) && supported));

endmodule

// File: tb/tb_mips_cpu_sequencer.sv
// Instruction-level reference bench: expected per-cycle outputs come from each instruction's phase list.
module tb_mips_cpu_sequencer;
    logic        clk = 1'b0;
    logic        reset, waitrequest;
    logic [5:0]  opcode, fncode;
    logic [31:0] pc;
    logic [2:0]  state, s_state;
    logic        advance, bus_enable, active, illegal;
    logic        s_advance, s_bus_enable, s_active, s_illegal;
    logic [31:0] instr_count;
    logic [2:0]  s_instr_count;

    int          checks = 0;
    int          errors = 0;
    longint unsigned retired;
    logic        exp_illegal;
    logic [5:0]  rfn [9] = '{6'h08, 6'h09, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26};

    mips_cpu_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .fncode(fncode), .pc(pc),
        .waitrequest(waitrequest), .state(state), .advance(advance),
        .bus_enable(bus_enable), .active(active), .illegal(illegal),
        .instr_count(instr_count)
    );

    mips_cpu_sequencer #(.COUNT_W(3)) dut_small (
        .clk(clk), .reset(reset), .opcode(opcode), .fncode(fncode), .pc(pc),
        .waitrequest(waitrequest), .state(s_state), .advance(s_advance),
        .bus_enable(s_bus_enable), .active(s_active), .illegal(s_illegal),
        .instr_count(s_instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_supported(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            foreach (rfn[i]) if (rfn[i] == fn) return 1'b1;
            return 1'b0;
        end
        return (op == 6'h04) || (op == 6'h05) || (op == 6'h23) || (op == 6'h2B);
    endfunction

    // One clock cycle: drive waitrequest, check all outputs mid-cycle, move past the edge.
    task automatic cyc(input logic wr, input logic [2:0] es, input logic ea, input logic eb);
        waitrequest = wr;
        @(negedge clk);
        check("state", state, es);
        check("advance", advance, ea);
        check("bus_enable", bus_enable, eb);
        check("active", active, es != 3'd0);
        check("illegal", illegal, exp_illegal);
        check("instr_count", instr_count, retired[31:0]);
        check("small_count", s_instr_count, retired % 8);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic wr);
        reset       = 1'b1;
        waitrequest = wr;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        retired     = 0;
        exp_illegal = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] p, input int fst);
        pc     = p;
        opcode = 6'($urandom);
        fncode = 6'($urandom);
        for (int i = 0; i < fst; i++) cyc(1'b1, 3'd1, 1'b0, 1'b1);
        cyc(1'b0, 3'd1, 1'b1, 1'b1);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] p,
                             input int fst, input int e1st, input int e2st);
        fetch(p, fst);
        opcode = op;
        fncode = fn;
        pc     = $urandom | 32'h4;
        cyc(1'($urandom), 3'd2, 1'b1, 1'b1);
        if (op == 6'h23) begin
            for (int i = 0; i < e1st; i++) cyc(1'b1, 3'd3, 1'b0, 1'b1);
            cyc(1'b0, 3'd3, 1'b1, 1'b1);
        end else begin
            cyc(1'($urandom), 3'd3, 1'b1, 1'b1);
        end
        if (op != 6'h04 && op != 6'h05) begin
            if (op == 6'h2B) begin
                for (int i = 0; i < e2st; i++) cyc(1'b1, 3'd4, 1'b0, 1'b1);
                cyc(1'b0, 3'd4, 1'b1, 1'b1);
            end else begin
                cyc(1'($urandom), 3'd4, 1'b1, 1'b1);
            end
        end
        retired++;
    endtask

    task automatic halt_run(input int n);
        pc     = 32'h0;
        opcode = 6'($urandom);
        cyc(1'($urandom), 3'd1, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) cyc(1'($urandom), 3'd0, 1'b0, 1'b0);
    endtask

    task automatic illegal_run(input logic [5:0] op, input logic [5:0] fn, input int n);
        fetch(32'h100 | ($urandom & 32'hFFF0), $urandom_range(0, 2));
        opcode = op;
        fncode = fn;
        cyc(1'($urandom), 3'd2, 1'b1, 1'b1);
        exp_illegal = 1'b1;
        for (int i = 0; i < n; i++) cyc(1'($urandom), 3'd0, 1'b0, 1'b0);
    endtask

    task automatic pick(output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        case ($urandom % 5)
            0: begin op = 6'h00; fn = rfn[$urandom % 9]; end
            1: op = 6'h04;
            2: op = 6'h05;
            3: op = 6'h23;
            default: op = 6'h2B;
        endcase
    endtask

    initial begin
        logic [5:0] op, fn;
        reset = 1'b1; waitrequest = 1'b0; opcode = '0; fncode = '0; pc = 32'hBFC0_0000;
        retired = 0; exp_illegal = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b0);

        run_instr(6'h00, 6'h21, 32'hBFC0_0000, 0, 0, 0);   // add: 1,2,3,4
        run_instr(6'h04, 6'h00, 32'hBFC0_0004, 0, 0, 0);   // beq: 1,2,3
        run_instr(6'h23, 6'h00, 32'hBFC0_0008, 3, 2, 0);   // lw with stalls
        do_reset(1'b0);
        run_instr(6'h2B, 6'h00, 32'hBFC0_000C, 1, 0, 3);   // sw, EXEC2 stall
        run_instr(6'h00, 6'h08, 32'hBFC0_0010, 0, 0, 0);   // jr to 0
        halt_run(4);
        check("count_after_halt", instr_count, 64'd2);
        do_reset(1'b1);
        illegal_run(6'h3F, 6'h00, 5);
        do_reset(1'b0);

        // Reset while EXEC1 is stalled on a load.
        fetch(32'h40, 0);
        opcode = 6'h23;
        cyc(1'b0, 3'd2, 1'b1, 1'b1);
        cyc(1'b1, 3'd3, 1'b0, 1'b1);
        cyc(1'b1, 3'd3, 1'b0, 1'b1);
        do_reset(1'b1);
        for (int i = 0; i < 9; i++) run_instr(6'h05, 6'h00, 32'h80 + 32'(i * 4), 0, 0, 0);
        check("small_wrap", s_instr_count, 64'd1);

        for (int n = 0; n < 250; n++) begin
            int r;
            r = $urandom % 40;
            if (r == 0) begin
                halt_run($urandom_range(1, 3));
                do_reset(1'($urandom));
            end else if (r == 1) begin
                do begin
                    op = 6'($urandom);
                    fn = 6'($urandom);
                end while (is_supported(op, fn));
                illegal_run(op, fn, $urandom_range(1, 3));
                do_reset(1'($urandom));
            end else begin
                pick(op, fn);
                run_instr(op, fn, $urandom | 32'h4, $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
